// File: rtl/sum_accumulator_pkg.sv
// Shared adder-path definitions: accumulator FSM states,
// default sum width and accumulator width derivation.
package sum_accumulator_pkg;

  localparam int DEF_DATA_W = 32;

  typedef enum logic {
    ACCUM = 1'b0,
    DONE  = 1'b1
  } state_e;

  function automatic int acc_w(
    input int data_w,
    input int guard_w
  );
    return data_w + guard_w;
  endfunction

endpackage

// File: rtl/sum_accumulator.sv
// Frame accumulator behind the adder stage: sums NUM_SAMPLES
// beats into a guarded total with a sticky overflow flag.
module sum_accumulator
  import sum_accumulator_pkg::*;
#(
  parameter int DATA_W      = DEF_DATA_W,
  parameter int GUARD_W     = 8,
  parameter int NUM_SAMPLES = 4,
  localparam int ACC_W      = acc_w(DATA_W, GUARD_W)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_sum,
  output logic              out_overflow
);

  localparam int CNT_W =
    (NUM_SAMPLES > 1) ? $clog2(NUM_SAMPLES + 1) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT =
    CNT_W'(NUM_SAMPLES - 1);

  state_e           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W-1:0] sum_q, sum_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             oovf_q, oovf_d;

  logic [ACC_W:0]   add;
  logic             accept;
  logic             last;
  logic             handoff;

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= ACCUM;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ACCUM: if (accept && last) state_d = DONE;
      DONE:  if (out_ready)      state_d = ACCUM;
    endcase
  end

  // Handshake outputs come from registered state only
  always_comb begin
    in_ready  = (state_q == ACCUM);
    out_valid = (state_q == DONE);
  end

  assign accept  = in_valid & in_ready;
  assign handoff = out_valid & out_ready;
  assign last    = (cnt_q == LAST_CNT);
  assign add     = {1'b0, acc_q} + (ACC_W + 1)'(in_data);

  always_comb begin
    acc_d  = acc_q;
    cnt_d  = cnt_q;
    ovf_d  = ovf_q;
    sum_d  = sum_q;
    oovf_d = oovf_q;
    if (accept) begin
      if (last) begin
        sum_d  = add[ACC_W-1:0];
        oovf_d = ovf_q | add[ACC_W];
      end else begin
        acc_d = add[ACC_W-1:0];
        cnt_d = cnt_q + CNT_W'(1);
        ovf_d = ovf_q | add[ACC_W];
      end
    end
    // Frame state clears as the result leaves
    if (handoff) begin
      acc_d = '0;
      cnt_d = '0;
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q  <= '0;
      cnt_q  <= '0;
      ovf_q  <= 1'b0;
      sum_q  <= '0;
      oovf_q <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      cnt_q  <= cnt_d;
      ovf_q  <= ovf_d;
      sum_q  <= sum_d;
      oovf_q <= oovf_d;
    end
  end

  assign out_sum      = sum_q;
  assign out_overflow = oovf_q;

endmodule
